// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 command sequencer.
package max7219_pkg;

  // MAX7219 register addresses (upper byte of every command word)
  localparam logic [7:0] REG_NOOP       = 8'h00;
  localparam logic [7:0] REG_DIGIT0     = 8'h01;
  localparam logic [7:0] REG_DECODE     = 8'h09;
  localparam logic [7:0] REG_INTENSITY  = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
  localparam logic [7:0] REG_DISP_TEST  = 8'h0F;

  // Number of words in the power-up sequence
  localparam logic [3:0] INIT_LEN = 4'd6;

  // Number of digit rows refreshed per pass
  localparam logic [3:0] ROW_COUNT = 4'd8;

  typedef enum logic [1:0] {
    INIT_LOAD,
    INIT,
    IDLE,
    REFRESH
  } seq_state_t;

  // Returns the i-th word of the power-up sequence
  function automatic logic [15:0] init_word(
    input logic [2:0] i,
    input logic [7:0] decode_mode,
    input logic [3:0] intensity,
    input logic [2:0] scan_limit
  );
    logic [15:0] w;
    case (i)
      3'd0:    w = {REG_SHUTDOWN, 8'h00};
      3'd1:    w = {REG_DISP_TEST, 8'h00};
      3'd2:    w = {REG_DECODE, decode_mode};
      3'd3:    w = {REG_INTENSITY, 4'h0, intensity};
      3'd4:    w = {REG_SCAN_LIMIT, 5'b00000, scan_limit};
      default: w = {REG_SHUTDOWN, 8'h01};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/max7219_frame_buf.sv
// 8x8 pixel frame buffer with a dirty flag that tells the sequencer a refresh is due.
module max7219_frame_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_data,
  input  logic       dirty_clr,
  output logic       dirty
);

  logic [7:0] rows_q [8];

  // Row storage: one row written per cycle, blanked on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        rows_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      rows_q[wr_row] <= wr_data;
    end
  end

  // Dirty flag: starts set so the display is blanked once; a write beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty <= 1'b1;
    end else if (wr_en) begin
      dirty <= 1'b1;
    end else if (dirty_clr) begin
      dirty <= 1'b0;
    end
  end

  assign rd_data = rows_q[rd_row];

endmodule

// File: rtl/max7219_cmd_seq.sv
// Command source for the MAX7219 serializer: power-up sequence, then row refreshes on frame change.
module max7219_cmd_seq
  import max7219_pkg::*;
#(
  parameter logic [7:0] DECODE_MODE = 8'h00,
  parameter logic [3:0] INTENSITY   = 4'h8,
  parameter logic [2:0] SCAN_LIMIT  = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [7:0]  wr_data,
  input  logic        reinit,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        init_done,
  output logic        busy
);

  seq_state_t  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [15:0] data_q, data_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        reinit_pend_q, reinit_pend_d;
  logic        dirty_clr;
  logic        dirty;
  logic [2:0]  rd_row;
  logic [7:0]  rd_data;
  logic        xfer;

  max7219_frame_buf u_frame_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .dirty_clr (dirty_clr),
    .dirty     (dirty)
  );

  assign xfer   = valid_q & cmd_ready;
  assign rd_row = (state_q == REFRESH) ? idx_q[2:0] : 3'd0;

  // Next-state logic; every new word is loaded on the edge that accepts the previous one
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    valid_d       = valid_q;
    data_d        = data_q;
    init_done_d   = init_done_q;
    reinit_pend_d = reinit_pend_q | reinit;
    dirty_clr     = 1'b0;
    case (state_q)
      INIT_LOAD: begin
        data_d  = init_word(3'd0, DECODE_MODE, INTENSITY, SCAN_LIMIT);
        valid_d = 1'b1;
        idx_d   = 4'd1;
        state_d = INIT;
      end
      INIT: begin
        if (xfer) begin
          if (idx_q == INIT_LEN) begin
            valid_d     = 1'b0;
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            data_d = init_word(idx_q[2:0], DECODE_MODE, INTENSITY, SCAN_LIMIT);
            idx_d  = idx_q + 4'd1;
          end
        end
      end
      IDLE: begin
        valid_d = 1'b0;
        if (reinit_pend_q) begin
          reinit_pend_d = reinit;
          init_done_d   = 1'b0;
          data_d        = init_word(3'd0, DECODE_MODE, INTENSITY, SCAN_LIMIT);
          valid_d       = 1'b1;
          idx_d         = 4'd1;
          state_d       = INIT;
        end else if (dirty) begin
          dirty_clr = 1'b1;
          data_d    = {REG_DIGIT0, rd_data};
          valid_d   = 1'b1;
          idx_d     = 4'd1;
          state_d   = REFRESH;
        end
      end
      REFRESH: begin
        if (xfer) begin
          if (idx_q == ROW_COUNT) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            data_d = {REG_DIGIT0 + {4'b0000, idx_q}, rd_data};
            idx_d  = idx_q + 4'd1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) || valid_d;
  end

  // State and output registers; reset drops any word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT_LOAD;
      idx_q         <= 4'd0;
      valid_q       <= 1'b0;
      data_q        <= {REG_NOOP, 8'h00};
      init_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      reinit_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
      reinit_pend_q <= reinit_pend_d;
    end
  end

  assign cmd_data  = data_q;
  assign cmd_valid = valid_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_max7219_cmd_seq.sv
// Self-checking bench for max7219_cmd_seq: captured command stream versus an expected word list.
module tb_max7219_cmd_seq;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [7:0]  wr_data;
  logic        reinit;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        init_done;
  logic        busy;

  int   ready_mode;
  logic rand_bit;
  logic manual_ready;

  int n_compared;
  int n_mismatched;
  int cyc;

  logic [7:0]  frame_m [8];
  logic [15:0] init_seq [6] = '{16'h0C00, 16'h0F00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01};

  logic [15:0] got_word [$];
  logic        got_done [$];
  int          got_cyc [$];
  logic [15:0] exp_word [$];
  logic        exp_done [$];

  logic        prev_stall;
  logic [15:0] prev_data;

  max7219_cmd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .reinit    (reinit),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .init_done (init_done),
    .busy      (busy)
  );

  // Mode 0: always ready, 1: random ready, 2: ready under direct control
  assign cmd_ready = (ready_mode == 1) ? rand_bit : (ready_mode == 2) ? manual_ready : 1'b1;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter and random ready source, updated just after each rising edge
  initial begin
    cyc      = 0;
    rand_bit = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      rand_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor on the falling edge: records transfers due at the next rising edge, checks stalls hold
  initial begin
    prev_stall = 1'b0;
    prev_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        checkOutput("stall_valid_held", {31'b0, cmd_valid}, 32'd1);
        checkOutput("stall_data_stable", {16'h0, cmd_data}, {16'h0, prev_data});
      end
      if (cmd_valid && cmd_ready && !rst) begin
        got_word.push_back(cmd_data);
        got_done.push_back(init_done);
        got_cyc.push_back(cyc);
      end
      prev_stall = cmd_valid && !cmd_ready && !rst;
      prev_data  = cmd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] row, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_row  = row;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic expInit();
    for (int i = 0; i < 6; i++) begin
      exp_word.push_back(init_seq[i]);
      exp_done.push_back(1'b0);
    end
  endtask

  task automatic expPass();
    for (int r = 0; r < 8; r++) begin
      exp_word.push_back({8'(r + 1), frame_m[r]});
      exp_done.push_back(1'b1);
    end
  endtask

  task automatic clearQueues();
    got_word.delete();
    got_done.delete();
    got_cyc.delete();
    exp_word.delete();
    exp_done.delete();
  endtask

  task automatic waitIdle(input string tag);
    int quiet;
    bit ok;
    quiet = 0;
    ok    = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if (!busy && !cmd_valid) quiet++;
      else quiet = 0;
      if (quiet >= 3) ok = 1'b1;
    end
    checkOutput({tag, "_settle"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic compareStream(input string tag, input bit check_done);
    int n;
    int m;
    n = got_word.size();
    m = exp_word.size();
    checkOutput({tag, "_count"}, 32'(n), 32'(m));
    for (int i = 0; i < ((n < m) ? n : m); i++) begin
      checkOutput($sformatf("%s_word%0d", tag, i), {16'h0, got_word[i]}, {16'h0, exp_word[i]});
      if (check_done)
        checkOutput($sformatf("%s_done%0d", tag, i), {31'b0, got_done[i]}, {31'b0, exp_done[i]});
    end
    clearQueues();
  endtask

  // Each pass must address digits 1..8 in order, and the last pass must show the final frame
  task automatic checkRandomPasses(input string tag);
    int n;
    n = got_word.size();
    checkOutput({tag, "_shape"}, 32'((n != 0) && (n % 8 == 0)), 32'd1);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), {24'h0, got_word[i][15:8]}, 32'((i % 8) + 1));
    if (n >= 8) begin
      for (int r = 0; r < 8; r++)
        checkOutput($sformatf("%s_row%0d", tag, r), {24'h0, got_word[n - 8 + r][7:0]}, {24'h0, frame_m[r]});
    end
    clearQueues();
  endtask

  // With ready held high, the init words and the first pass arrive on consecutive cycles
  task automatic checkBackToBack();
    if (got_cyc.size() >= 14) begin
      for (int i = 0; i < 13; i++) begin
        if (i != 5)
          checkOutput($sformatf("b2b_gap%0d", i), 32'(got_cyc[i + 1] - got_cyc[i]), 32'd1);
      end
    end
  endtask

  // Directed and randomized scenarios, in order
  initial begin
    bit         found;
    logic [7:0] d;
    int         nw;
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_row       = 3'd0;
    wr_data      = 8'h00;
    reinit       = 1'b0;
    ready_mode   = 0;
    manual_ready = 1'b0;
    for (int r = 0; r < 8; r++) frame_m[r] = 8'h00;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_valid", {31'b0, cmd_valid}, 32'd0);
    checkOutput("rst_data", {16'h0, cmd_data}, 32'h0000);
    checkOutput("rst_init_done", {31'b0, init_done}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    clearQueues();

    $display("[TB] init and blanking pass, ready always high");
    rst = 1'b0;
    tick();
    checkOutput("first_valid", {31'b0, cmd_valid}, 32'd1);
    checkOutput("first_word", {16'h0, cmd_data}, 32'h0C00);
    expInit();
    expPass();
    waitIdle("s1");
    checkOutput("s1_init_done", {31'b0, init_done}, 32'd1);
    checkBackToBack();
    compareStream("s1", 1'b1);

    $display("[TB] init and blanking pass, random ready");
    rst = 1'b1;
    repeat (2) tick();
    ready_mode = 1;
    rst = 1'b0;
    expInit();
    expPass();
    waitIdle("s2");
    compareStream("s2", 1'b1);

    $display("[TB] reinit during init");
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    expInit();
    expInit();
    expPass();
    waitIdle("s7");
    checkOutput("s7_init_done", {31'b0, init_done}, 32'd1);
    compareStream("s7", 1'b1);

    $display("[TB] single row write");
    applyStimulus(3'd2, 8'hA5);
    frame_m[2] = 8'hA5;
    expPass();
    waitIdle("s3");
    compareStream("s3", 1'b1);

    $display("[TB] random writes");
    for (int it = 0; it < 6; it++) begin
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        wr_row = 3'($urandom_range(0, 7));
        d = 8'($urandom);
        frame_m[wr_row] = d;
        applyStimulus(wr_row, d);
        repeat ($urandom_range(0, 3)) tick();
      end
      waitIdle($sformatf("rnd%0d", it));
      checkRandomPasses($sformatf("rnd%0d", it));
    end

    $display("[TB] write during stalled row 6");
    ready_mode   = 2;
    manual_ready = 1'b0;
    d = 8'($urandom);
    applyStimulus(3'd0, d);
    frame_m[0] = d;
    expPass();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (cmd_valid && cmd_data[15:8] == 8'h07) begin
        found = 1'b1;
        manual_ready = 1'b0;
      end else begin
        manual_ready = cmd_valid;
      end
    end
    checkOutput("s4_reach_row6", {31'b0, found}, 32'd1);
    repeat (2) tick();
    checkOutput("s4_stalled_addr", {24'h0, cmd_data[15:8]}, 32'h07);
    applyStimulus(3'd5, 8'h3C);
    tick();
    frame_m[5] = 8'h3C;
    expPass();
    ready_mode = 0;
    waitIdle("s4");
    compareStream("s4", 1'b1);

    $display("[TB] reinit during refresh");
    ready_mode = 1;
    d = 8'($urandom);
    applyStimulus(3'd7, d);
    frame_m[7] = d;
    tick();
    checkOutput("s5_pass_active", {31'b0, cmd_valid}, 32'd1);
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    expPass();
    expInit();
    waitIdle("s5");
    checkOutput("s5_init_done", {31'b0, init_done}, 32'd1);
    compareStream("s5", 1'b1);

    $display("[TB] reset while stalled");
    ready_mode   = 2;
    manual_ready = 1'b0;
    applyStimulus(3'd3, 8'($urandom));
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (cmd_valid) found = 1'b1;
    end
    checkOutput("s6_valid_before_rst", {31'b0, found}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("s6_rst_valid", {31'b0, cmd_valid}, 32'd0);
    checkOutput("s6_rst_data", {16'h0, cmd_data}, 32'h0000);
    checkOutput("s6_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("s6_rst_init_done", {31'b0, init_done}, 32'd0);
    compareStream("s6_none", 1'b0);
    for (int r = 0; r < 8; r++) frame_m[r] = 8'h00;
    tick();
    rst = 1'b0;
    ready_mode = 0;
    expInit();
    expPass();
    waitIdle("s6");
    compareStream("s6", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
